regfile_mp: RTL and testbench

- Parametrised successor to the core's 2-read/1-write integer register file.
- Configurable data width, register count and number of synchronous read ports.
- Write-first bypass on every read port; read-enable/hold per port with coherent hold (a held word tracks later writes to its address).
- Post-reset hardware clear sequencer zeroes the array and gates the pipeline through `ready`. Sits between decode (read addresses) and writeback (write port).

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_rdport.sv | 58 +++++
 rtl/regfile_mp.sv | 89 ++++++++
 tb/tb_regfile_mp.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: FSM state encoding,
// default sizes and slice helpers for the flattened per-port buses.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  // FSM state encoding
  localparam logic RF_CLEAR = 1'b0;
  localparam logic RF_RUN   = 1'b1;

  // Low bit of port 'port' inside a flattened bus of 'width'-bit fields.
  function automatic int unsigned rf_idx_slice(input int unsigned port,
                                               input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One synchronous read port: captures the read address, keeps a hold address,
// applies write-first bypass and coherent-hold updates, registers the word.
// Optional macro REGFILE_MP_X0_ZERO_EN forces reads/holds of address 0 to zero.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            re,
  input  logic [AW-1:0]   ra,
  input  logic [XLEN-1:0] mem_word,
  input  logic            wr_en,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rdata
);

  logic [AW-1:0]   hold_q, hold_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  // Next-state: new read with bypass, or refresh the held word on a matching write
  always_comb begin
    hold_d  = hold_q;
    rdata_d = rdata_q;
    if (run) begin
      if (re) begin
        hold_d  = ra;
        rdata_d = (wr_en && (wa == ra)) ? wd : mem_word;
`ifdef REGFILE_MP_X0_ZERO_EN
        if (ra == '0) rdata_d = '0;
`endif
      end else if (wr_en && (wa == hold_q)) begin
        rdata_d = wd;
`ifdef REGFILE_MP_X0_ZERO_EN
        if (hold_q == '0) rdata_d = rdata_q;
`endif
      end
    end
  end

  // Port state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q  <= '0;
      rdata_q <= '0;
    end else begin
      hold_q  <= hold_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with a post-reset clear sequencer.
// The array and the clear FSM live here; each read port is a regfile_rdport.
// Optional macro REGFILE_MP_X0_ZERO_EN makes entry 0 read as zero and drops its writes.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ready,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic [NRD-1:0]      re,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rdata
);

  localparam logic [AW-1:0] LastIdx = AW'(NREG - 1);

  logic            state_q;
  logic [AW-1:0]   idx_q;
  logic [XLEN-1:0] mem [NREG];
  logic            run;
  logic            wr_en;

  assign run   = (state_q == RF_RUN);
  assign ready = run;

`ifdef REGFILE_MP_X0_ZERO_EN
  assign wr_en = we && run && (wa != '0);
`else
  assign wr_en = we && run;
`endif

  // Clear sequencer: one entry per cycle after reset, then RUN until next reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RF_CLEAR;
      idx_q   <= '0;
    end else if (state_q == RF_CLEAR) begin
      idx_q <= idx_q + AW'(1);
      if (idx_q == LastIdx) state_q <= RF_RUN;
    end
  end

  // Array: zeroed by the sequencer, written by writeback in RUN; untouched during reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!run) begin
        mem[idx_q] <= '0;
      end else if (wr_en) begin
        mem[wa] <= wd;
      end
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_port
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] word;
    logic [XLEN-1:0] rd;

    assign addr = ra[rf_idx_slice(g, AW) +: AW];
    assign word = mem[addr];

    regfile_rdport #(
      .XLEN(XLEN),
      .AW  (AW)
    ) u_rdport (
      .clk     (clk),
      .reset   (reset),
      .run     (run),
      .re      (re[g]),
      .ra      (addr),
      .mem_word(word),
      .wr_en   (wr_en),
      .wa      (wa),
      .wd      (wd),
      .rdata   (rd)
    );

    assign rdata[rf_idx_slice(g, XLEN) +: XLEN] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, multi-cycle reset
// sequences and randomized traffic against a behavioural model of the file.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;

`ifdef REGFILE_MP_X0_ZERO_EN
  localparam bit X0 = 1'b1;
`else
  localparam bit X0 = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                ready;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic [NRD-1:0]      re;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rdata;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN(XLEN),
    .NREG(NREG),
    .NRD (NRD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .ready(ready),
    .we   (we),
    .wa   (wa),
    .wd   (wd),
    .re   (re),
    .ra   (ra),
    .rdata(rdata)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: storage, remaining clear cycles, per-port hold/output
  logic [XLEN-1:0] m_mem [NREG];
  int              m_clear_left;
  int              m_hold [NRD];
  logic [XLEN-1:0] m_rd [NRD];

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply the rules for one rising edge with the given inputs
  task automatic model_edge(input logic rst, input logic w, input int a,
                            input logic [XLEN-1:0] d, input logic [1:0] r,
                            input int a0, input int a1);
    int  addr;
    bit  wr;
    if (rst) begin
      m_clear_left = NREG;
      for (int p = 0; p < NRD; p++) begin
        m_hold[p] = 0;
        m_rd[p]   = '0;
      end
      return;
    end
    if (m_clear_left > 0) begin
      m_mem[NREG - m_clear_left] = '0;
      m_clear_left--;
      return;
    end
    wr = w && !(X0 && a == 0);
    for (int p = 0; p < NRD; p++) begin
      addr = (p == 0) ? a0 : a1;
      if (r[p]) begin
        m_hold[p] = addr;
        m_rd[p]   = (wr && a == addr) ? d : m_mem[addr];
        if (X0 && addr == 0) m_rd[p] = '0;
      end else if (wr && a == m_hold[p]) begin
        m_rd[p] = d;
      end
    end
    if (wr) m_mem[a] = d;
  endtask

  // Drive one cycle, advance past the edge, compare with the model
  task automatic step(input logic rst, input logic w, input int a,
                      input logic [XLEN-1:0] d, input logic [1:0] r,
                      input int a0, input int a1);
    reset = rst;
    we    = w;
    wa    = AW'(a);
    wd    = d;
    re    = r;
    ra    = {AW'(a1), AW'(a0)};
    model_edge(rst, w, a, d, r, a0, a1);
    @(posedge clk);
    #1;
    check("model_rdata0", rdata[XLEN-1:0], m_rd[0]);
    check("model_rdata1", rdata[2*XLEN-1:XLEN], m_rd[1]);
    check("model_ready", {31'b0, ready}, {31'b0, m_clear_left == 0});
  endtask

  // Run the clear window with a dropped write to r9 pending, return its length
  task automatic clear_len(output int n);
    n = 0;
    do begin
      step(1'b0, 1'b1, 9, 32'h0000_0099, 2'b11, 9, 9);
      n++;
    end while (!ready && n < 40);
  endtask

  typedef struct {
    logic            we;
    int              wa;
    logic [XLEN-1:0] wd;
    logic [1:0]      re;
    int              ra0;
    int              ra1;
    logic [XLEN-1:0] exp0;
    logic [XLEN-1:0] exp1;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int n;
    logic [XLEN-1:0] x0v;
    x0v = X0 ? 32'h0 : 32'hFFFF_FFFF;

    // bypass, coherent hold, back-to-back, entry 0
    tbl[0]  = '{1'b1, 5, 32'hDEADBEEF, 2'b11, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[1]  = '{1'b1, 7, 32'h11, 2'b00, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 0, 32'h0, 2'b01, 7, 0, 32'h11, 32'hDEADBEEF};
    tbl[3]  = '{1'b1, 7, 32'h22, 2'b00, 0, 0, 32'h22, 32'hDEADBEEF};
    tbl[4]  = '{1'b1, 8, 32'h33, 2'b00, 0, 0, 32'h22, 32'hDEADBEEF};
    tbl[5]  = '{1'b1, 5, 32'h55, 2'b00, 0, 0, 32'h22, 32'h55};
    tbl[6]  = '{1'b1, 1, 32'h101, 2'b00, 0, 0, 32'h22, 32'h55};
    tbl[7]  = '{1'b1, 2, 32'h202, 2'b01, 1, 0, 32'h101, 32'h55};
    tbl[8]  = '{1'b1, 3, 32'h303, 2'b10, 0, 2, 32'h101, 32'h202};
    tbl[9]  = '{1'b1, 4, 32'h404, 2'b01, 3, 0, 32'h303, 32'h202};
    tbl[10] = '{1'b0, 0, 32'h0, 2'b10, 0, 4, 32'h303, 32'h404};
    tbl[11] = '{1'b1, 0, 32'hFFFF_FFFF, 2'b01, 0, 0, x0v, 32'h404};
    tbl[12] = '{1'b0, 0, 32'h0, 2'b11, 0, 0, x0v, x0v};

    // initial reset and clear
    step(1'b1, 1'b0, 0, '0, 2'b00, 0, 0);
    check("reset_rdata0", rdata[XLEN-1:0], 32'h0);
    check("reset_ready", {31'b0, ready}, 32'h0);
    clear_len(n);
    check("first_clear_len", n, 32);

    // preload every entry, then reset and re-clear
    for (int i = 0; i < NREG; i++) step(1'b0, 1'b1, i, 32'h0101_0101 * i + 1, 2'b00, 0, 0);
    step(1'b1, 1'b0, 0, '0, 2'b00, 0, 0);
    clear_len(n);
    check("clear_len", n, 32);
    for (int i = 0; i < NREG; i++) begin
      step(1'b0, 1'b0, 0, '0, 2'b11, i, NREG - 1 - i);
      check("clear_rd0", rdata[XLEN-1:0], 32'h0);
      check("clear_rd1", rdata[2*XLEN-1:XLEN], 32'h0);
    end

    // directed vector table
    for (int i = 0; i < 13; i++) begin
      step(1'b0, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra0, tbl[i].ra1);
      check($sformatf("vec%0d_rd0", i), rdata[XLEN-1:0], tbl[i].exp0);
      check($sformatf("vec%0d_rd1", i), rdata[2*XLEN-1:XLEN], tbl[i].exp1);
    end

    // reset reasserted at clear cycle 10
    step(1'b1, 1'b0, 0, '0, 2'b00, 0, 0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 9, 32'h99, 2'b00, 0, 0);
    step(1'b1, 1'b0, 0, '0, 2'b00, 0, 0);
    clear_len(n);
    check("midclear_len", n, 32);
    step(1'b0, 1'b0, 0, '0, 2'b01, 9, 0);
    check("dropped_write_r9", rdata[XLEN-1:0], 32'h0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 149) == 0, 1'($urandom), int'($urandom_range(0, NREG - 1)),
           $urandom, 2'($urandom), int'($urandom_range(0, NREG - 1)),
           int'($urandom_range(0, NREG - 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
